// File: rtl/axis_upsizer_pkg.sv
// Shared types for the AXI-Stream width upsizer.
package axis_upsizer_pkg;

  // What the current input cycle does to the packing state.
  typedef enum logic [1:0] {
    BEAT_IDLE     = 2'd0,  // no valid input word
    BEAT_STORE    = 2'd1,  // word written into accumulator, counter advances
    BEAT_COMPLETE = 2'd2,  // word closes an output word and is accepted
    BEAT_STALL    = 2'd3   // word would close an output word but output stage is full
  } beat_kind_e;

endpackage

// File: rtl/axis_upsizer_output_buffer.sv
// One-deep registered output slice: holds a word until the sink takes it,
// and refills in the same cycle it drains so a stream runs without bubbles.
module output_buffer #(
  parameter int DATA_WIDTH = 129
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready
);

  assign in_ready = ~out_valid | out_ready;

  // Load a new word whenever the slot is empty or being drained; data only
  // changes on a load, so it stays stable while the sink stalls.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_data <= in_data;
      end
    end
  end

endmodule

// File: rtl/axis_upsizer.sv
// Packs narrow AXI-Stream words into wide words. cfg_data selects how many
// narrow words make one wide word; tlast flushes a partial word early with
// the unwritten upper slices left at zero.
module axis_upsizer
  import axis_upsizer_pkg::*;
#(
  parameter int S_AXIS_TDATA_WIDTH = 32,
  parameter int M_AXIS_TDATA_WIDTH = 128
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic [15:0]                   cfg_data,
  input  logic [S_AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                          s_axis_tvalid,
  input  logic                          s_axis_tlast,
  output logic                          s_axis_tready,
  output logic [M_AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                          m_axis_tvalid,
  output logic                          m_axis_tlast,
  input  logic                          m_axis_tready
);

  localparam int RATIO      = M_AXIS_TDATA_WIDTH / S_AXIS_TDATA_WIDTH;
  localparam int CNTR_WIDTH = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int SW         = S_AXIS_TDATA_WIDTH;
  localparam logic [CNTR_WIDTH-1:0] MAX_IDX = CNTR_WIDTH'(RATIO - 1);

  logic [CNTR_WIDTH-1:0]         cntr;
  logic [CNTR_WIDTH-1:0]         cfg_lim;
  logic [CNTR_WIDTH-1:0]         lim;
  logic [M_AXIS_TDATA_WIDTH-1:0] acc;
  logic [M_AXIS_TDATA_WIDTH-1:0] word;
  logic                          end_cond;
  logic                          buf_valid;
  logic                          buf_ready;
  logic [M_AXIS_TDATA_WIDTH:0]   buf_out;
  logic                          unused_cfg;
  beat_kind_e                    beat;

  // Upper cfg bits are ignored; a limit beyond the slice count saturates.
  assign cfg_lim    = cfg_data[CNTR_WIDTH-1:0];
  assign lim        = (cfg_lim > MAX_IDX) ? MAX_IDX : cfg_lim;
  assign unused_cfg = ^cfg_data;

  // >= rather than == so lowering cfg mid-word closes the word on the next beat.
  assign end_cond = (cntr >= lim) | s_axis_tlast;

  // Accumulator with the current input word dropped into slice cntr.
  always_comb begin
    word = acc;
    for (int j = 0; j < RATIO; j++) begin
      if (CNTR_WIDTH'(j) == cntr) begin
        word[j*SW +: SW] = s_axis_tdata;
      end
    end
  end

  // Classify the cycle; reset blocks any store or hand-off to the output stage.
  always_comb begin
    beat          = BEAT_IDLE;
    buf_valid     = 1'b0;
    s_axis_tready = 1'b1;
    if (!aresetn) begin
      s_axis_tready = (lim != '0);
    end else begin
      s_axis_tready = end_cond ? buf_ready : 1'b1;
      buf_valid     = s_axis_tvalid & end_cond;
      if (s_axis_tvalid) begin
        if (!end_cond) begin
          beat = BEAT_STORE;
        end else if (buf_ready) begin
          beat = BEAT_COMPLETE;
        end else begin
          beat = BEAT_STALL;
        end
      end
    end
  end

  // Slice counter and accumulator; a completed word restarts from a clean slate
  // so unwritten slices of the next word read as zero.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      cntr <= '0;
      acc  <= '0;
    end else begin
      case (beat)
        BEAT_STORE: begin
          acc  <= word;
          cntr <= cntr + 1'b1;
        end
        BEAT_COMPLETE: begin
          acc  <= '0;
          cntr <= '0;
        end
        default: ;
      endcase
    end
  end

  output_buffer #(
    .DATA_WIDTH(M_AXIS_TDATA_WIDTH + 1)
  ) u_out_buf (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .in_data   ({s_axis_tlast, word}),
    .in_valid  (buf_valid),
    .in_ready  (buf_ready),
    .out_data  (buf_out),
    .out_valid (m_axis_tvalid),
    .out_ready (m_axis_tready)
  );

  assign m_axis_tlast = buf_out[M_AXIS_TDATA_WIDTH];
  assign m_axis_tdata = buf_out[M_AXIS_TDATA_WIDTH-1:0];

endmodule

// File: tb/tb_axis_upsizer.sv
// Scoreboard bench for axis_upsizer with 32-bit in / 128-bit out.
module tb_axis_upsizer;

  localparam int S = 32;
  localparam int M = 128;

  logic          aclk = 1'b0;
  logic          aresetn;
  logic [15:0]   cfg_data;
  logic [S-1:0]  s_axis_tdata;
  logic          s_axis_tvalid;
  logic          s_axis_tlast;
  logic          s_axis_tready;
  logic [M-1:0]  m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tlast;
  logic          m_axis_tready;

  axis_upsizer #(
    .S_AXIS_TDATA_WIDTH(S),
    .M_AXIS_TDATA_WIDTH(M)
  ) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .cfg_data      (cfg_data),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready)
  );

  always #5 aclk = ~aclk;

  logic [M:0] exp_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [M:0] held;
  bit         held_v = 1'b0;

  task automatic check(input string name, input logic [M:0] act, input logic [M:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  task automatic push_exp(input logic last, input logic [M-1:0] data);
    exp_q.push_back({last, data});
  endtask

  // Monitor: compare every accepted output word against the scoreboard and
  // confirm a stalled word does not change.
  always @(negedge aclk) begin
    if (aresetn && m_axis_tvalid) begin
      if (held_v) check("hold_stable", {m_axis_tlast, m_axis_tdata}, held);
      if (m_axis_tready) begin
        held_v = 1'b0;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_word: got %h want none", {m_axis_tlast, m_axis_tdata});
        end else begin
          check("out_word", {m_axis_tlast, m_axis_tdata}, exp_q.pop_front());
        end
      end else begin
        held   = {m_axis_tlast, m_axis_tdata};
        held_v = 1'b1;
      end
    end else begin
      held_v = 1'b0;
    end
  end

  // Present one input word, wait (bounded) for acceptance, return at edge+1.
  task automatic send(input logic [S-1:0] data, input logic last);
    int t;
    s_axis_tdata  = data;
    s_axis_tlast  = last;
    s_axis_tvalid = 1'b1;
    t = 0;
    @(negedge aclk);
    while (!s_axis_tready && t < 50) begin
      t++;
      @(negedge aclk);
    end
    if (t >= 50) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: got s_axis_tready=0 want 1");
    end
    @(posedge aclk);
    #1;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  initial begin
    int t;
    aresetn       = 1'b0;
    cfg_data      = 16'd3;
    s_axis_tdata  = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    m_axis_tready = 1'b1;

    // Reset state
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    check("rst_tvalid", m_axis_tvalid, 1'b0);
    check("rst_tlast", m_axis_tlast, 1'b0);
    check("rst_tdata", m_axis_tdata, '0);
    check("rst_ready_l3", s_axis_tready, 1'b1);
    cfg_data = 16'd0;
    #1;
    check("rst_ready_l0", s_axis_tready, 1'b0);
    @(posedge aclk);
    #1;
    cfg_data = 16'd3;
    aresetn  = 1'b1;
    @(posedge aclk);
    #1;

    // Full word, one-cycle latency
    push_exp(1'b0, 128'h44444444_33333333_22222222_11111111);
    send(32'h11111111, 1'b0);
    send(32'h22222222, 1'b0);
    send(32'h33333333, 1'b0);
    send(32'h44444444, 1'b0);
    check("latency_tvalid", m_axis_tvalid, 1'b1);
    @(posedge aclk);
    #1;

    // Two slices per word, back to back
    cfg_data = 16'd1;
    push_exp(1'b0, 128'h0000000B_0000000A);
    push_exp(1'b0, 128'h0000000D_0000000C);
    send(32'hA, 1'b0);
    send(32'hB, 1'b0);
    send(32'hC, 1'b0);
    send(32'hD, 1'b0);

    // tlast flush, then the next word starts at slice 0
    cfg_data = 16'd3;
    push_exp(1'b1, 128'h00000000_00000003_00000002_00000001);
    push_exp(1'b0, 128'h0000000D_0000000C_0000000B_0000000A);
    send(32'h1, 1'b0);
    send(32'h2, 1'b0);
    send(32'h3, 1'b1);
    send(32'hA, 1'b0);
    send(32'hB, 1'b0);
    send(32'hC, 1'b0);
    send(32'hD, 1'b0);
    @(posedge aclk);
    #1;

    // Backpressure: second word stalls on its closing beat
    m_axis_tready = 1'b0;
    push_exp(1'b0, 128'h00000103_00000102_00000101_00000100);
    push_exp(1'b0, 128'h00000203_00000202_00000201_00000200);
    send(32'h100, 1'b0);
    send(32'h101, 1'b0);
    send(32'h102, 1'b0);
    send(32'h103, 1'b0);
    send(32'h200, 1'b0);
    send(32'h201, 1'b0);
    send(32'h202, 1'b0);
    s_axis_tdata  = 32'h203;
    s_axis_tvalid = 1'b1;
    repeat (3) begin
      @(negedge aclk);
      check("stall_ready", s_axis_tready, 1'b0);
    end
    @(posedge aclk);
    #1;
    m_axis_tready = 1'b1;
    @(negedge aclk);
    check("unstall_ready", s_axis_tready, 1'b1);
    @(posedge aclk);
    #1;
    s_axis_tvalid = 1'b0;
    @(posedge aclk);
    #1;

    // Oversized cfg saturates to four slices
    cfg_data = 16'd7;
    push_exp(1'b0, 128'h00000074_00000073_00000072_00000071);
    send(32'h71, 1'b0);
    send(32'h72, 1'b0);
    send(32'h73, 1'b0);
    send(32'h74, 1'b0);

    // cfg lowered 3 -> 1 with two slices filled closes the word on the next beat
    cfg_data = 16'd3;
    push_exp(1'b0, 128'h00000000_000000E3_000000E2_000000E1);
    send(32'hE1, 1'b0);
    send(32'hE2, 1'b0);
    cfg_data = 16'd1;
    send(32'hE3, 1'b0);
    @(posedge aclk);
    #1;

    // Reset mid-word discards the partial word
    cfg_data = 16'd3;
    send(32'hF1, 1'b0);
    send(32'hF2, 1'b0);
    aresetn = 1'b0;
    repeat (2) @(posedge aclk);
    #1;
    aresetn = 1'b1;
    @(negedge aclk);
    check("post_rst_tvalid", m_axis_tvalid, 1'b0);
    @(posedge aclk);
    #1;
    push_exp(1'b0, 128'h00000054_00000053_00000052_00000051);
    send(32'h51, 1'b0);
    send(32'h52, 1'b0);
    send(32'h53, 1'b0);
    send(32'h54, 1'b0);

    // Drain
    t = 0;
    while (exp_q.size() != 0 && t < 100) begin
      t++;
      @(negedge aclk);
    end
    repeat (3) @(negedge aclk);
    check("queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/axis_upsizer.md
AXIS_UPSIZER -- requirements
Module: axis_upsizer

Interface
REQ-001 Parameter S_AXIS_TDATA_WIDTH, default 32: input word width.
REQ-002 Parameter M_AXIS_TDATA_WIDTH, default 128: output word width, an integer multiple of S_AXIS_TDATA_WIDTH.
REQ-003 aclk  input  1  clock; all logic SHALL be synchronous to its rising edge.
REQ-004 aresetn  input  1  reset, synchronous, active-low.
REQ-005 cfg_data  input  16  input words per output minus one; only bits [CNTR_WIDTH-1:0] SHALL be used.
REQ-006 s_axis_tdata  input  S_AXIS_TDATA_WIDTH  narrow input word.
REQ-007 s_axis_tvalid  input  1  input word valid.
REQ-008 s_axis_tlast  input  1  packet end; flushes a partial output word.
REQ-009 s_axis_tready  output  1  input accepted when high with tvalid.
REQ-010 m_axis_tdata  output  M_AXIS_TDATA_WIDTH  packed wide word.
REQ-011 m_axis_tvalid  output  1  output word valid.
REQ-012 m_axis_tlast  output  1  output word closes a packet.
REQ-013 m_axis_tready  input  1  downstream ready.

Function
REQ-014 RATIO = M/S width; CNTR_WIDTH = clog2(RATIO), minimum 1.
REQ-015 Effective limit L SHALL be min(cfg_data[CNTR_WIDTH-1:0], RATIO-1).
REQ-016 Slice counter cntr SHALL index the slice written by the current input beat; slice j occupies bits [j*S+:S].
REQ-017 Completing beat: s_axis_tvalid & (cntr >= L | s_axis_tlast); the >= compare SHALL absorb a mid-packet reduction of cfg_data.
REQ-018 Non-completing beats SHALL see s_axis_tready=1 and store s_axis_tdata into accumulator slice cntr, then cntr+1.
REQ-019 A completing beat SHALL present {accumulator with slice cntr replaced by s_axis_tdata} plus tlast=s_axis_tlast to the output stage; s_axis_tready SHALL equal output-stage in_ready.
REQ-020 On an accepted completing beat, cntr SHALL return to 0 and the accumulator SHALL clear to all zeros.
REQ-021 Slices above the last written index in any output word SHALL be zero (partial flush and L<RATIO-1).
REQ-022 The output stage SHALL be a one-deep registered slice: in_ready = ~m_axis_tvalid | m_axis_tready; latency from completing beat to m_axis_tvalid = 1 cycle.
REQ-023 Sustained throughput SHALL be one input beat per cycle with m_axis_tready held high; no bubbles between output words.
REQ-024 m_axis_tdata/m_axis_tlast SHALL remain stable while m_axis_tvalid & ~m_axis_tready.
REQ-025 cfg_data is quasi-static; a change SHALL take effect at the next beat without corrupting words already in the output stage.

Reset
REQ-026 While aresetn low: cntr=0, accumulator=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0.
REQ-027 s_axis_tready SHALL be 1 during reset only if L>0; no beat SHALL be stored during reset.
REQ-028 Reset mid-packet SHALL discard the partial word and any unsent output word; the first beat after reset lands in slice 0.

Structure
REQ-029 RATIO and CNTR_WIDTH SHALL be module-local derived constants; no shared package entries.
REQ-030 The output stage SHALL be the existing output_buffer sub-module (DATA_WIDTH = M_AXIS_TDATA_WIDTH+1, tlast carried as MSB).
REQ-031 Counter, accumulator and completion logic SHALL live in axis_upsizer; estimated 120-200 lines.

Verification (S=32, M=128)
REQ-032 cfg=3, beats 0x11111111,0x22222222,0x33333333,0x44444444, tready=1 -> one word 0x44444444_33333333_22222222_11111111, tlast=0, one cycle after beat 4.
REQ-033 cfg=1, beats 0xA,0xB,0xC,0xD -> two words 0x0..0_0000000B_0000000A and 0x0..0_0000000D_0000000C.
REQ-034 cfg=3, beats 0x1,0x2,0x3(tlast) -> word 0x00000000_00000003_00000002_00000001, m_axis_tlast=1; next beat lands in slice 0.
REQ-035 m_axis_tready=0 with one word held: beats 1-3 of next word accepted, beat 4 stalls (s_axis_tready=0) until tready=1; both words intact, order kept.
REQ-036 cfg=7 -> behaves as cfg=3; cfg changed 3->1 with cntr=2 -> next beat completes the word.
REQ-037 aresetn pulsed low after two beats -> no output, m_axis_tvalid=0; next four beats form a clean word.
